// File: rtl/cpu_peripheral_responder_if.sv
// Purpose: CPU valid/ready request/response bus in the clk_2x domain.
// Signals:
//   cpu_mem_valid_2x   request valid (master -> slave)
//   cpu_address_2x     request byte address
//   cpu_write_data_2x  write data
//   cpu_wstrb_2x       byte strobes, 0 = read
//   cpu_mem_ready      response ready, held until valid drops (slave -> master)
//   cpu_read_data      response read data
interface cpu_peripheral_responder_if;
  logic        cpu_mem_valid_2x;
  logic [31:0] cpu_address_2x;
  logic [31:0] cpu_write_data_2x;
  logic [3:0]  cpu_wstrb_2x;
  logic        cpu_mem_ready;
  logic [31:0] cpu_read_data;

  modport master (
    output cpu_mem_valid_2x, cpu_address_2x, cpu_write_data_2x, cpu_wstrb_2x,
    input  cpu_mem_ready, cpu_read_data
  );

  modport slave (
    input  cpu_mem_valid_2x, cpu_address_2x, cpu_write_data_2x, cpu_wstrb_2x,
    output cpu_mem_ready, cpu_read_data
  );
endinterface

// File: rtl/cpu_peripheral_responder.sv
// Purpose: responder end of the CPU valid/ready bus. Decodes one of four peripheral
// regions, issues a one-cycle read/write strobe, waits for the region ack and returns
// ready + read data, holding ready until the requester drops valid.
// Optional feature macro: BUS_TIMEOUT_EN (bounded WAIT with sticky timeout_flag_o).
// Ports:
//   clk_2x, reset          clock, asynchronous active-high reset
//   bus (slave)            CPU request/response bus
//   periph_sel_o           one-hot region select, high from strobe until ack
//   periph_re_o/we_o       one-cycle read/write strobes
//   periph_address_o       latched low address bits
//   periph_write_data_o    latched write data
//   periph_wstrb_o         latched byte strobes
//   periph_read_data_i     region i read data on [32*i+31:32*i]
//   periph_ack_i           per-region completion, may be combinational on strobe
//   timeout_flag_o         sticky timeout indicator
module cpu_peripheral_responder #(
  parameter int unsigned DECODE_LSB        = 24,
  parameter int unsigned PERIPH_ADDR_WIDTH = 16,
  parameter logic [3:0]  REGION_MASK       = 4'b1111,
  parameter int unsigned TIMEOUT_CYCLES    = 255,
  parameter logic [31:0] TIMEOUT_DATA      = 32'hDEADBEEF
) (
  input  logic                         clk_2x,
  input  logic                         reset,
  cpu_peripheral_responder_if.slave    bus,
  output logic [3:0]                   periph_sel_o,
  output logic                         periph_re_o,
  output logic                         periph_we_o,
  output logic [PERIPH_ADDR_WIDTH-1:0] periph_address_o,
  output logic [31:0]                  periph_write_data_o,
  output logic [3:0]                   periph_wstrb_o,
  input  logic [127:0]                 periph_read_data_i,
  input  logic [3:0]                   periph_ack_i,
  output logic                         timeout_flag_o
);
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REGIONS = 4;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESPOND} state_e;

  state_e                       state_q, state_d;
  logic                         ready_q, ready_d;
  logic [DATA_W-1:0]            rdata_q, rdata_d;
  logic [REGIONS-1:0]           sel_q, sel_d;
  logic                         re_q, re_d;
  logic                         we_q, we_d;
  logic [PERIPH_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]            wdata_q, wdata_d;
  logic [3:0]                   wstrb_q, wstrb_d;

  logic [1:0]                   req_region_c;
  logic [REGIONS-1:0]           req_sel_c;
  logic                         req_mapped_c;
  logic                         ack_hit_c;
  logic [DATA_W-1:0]            ack_data_c;
  logic                         unused_c;

`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [CNT_W-1:0]             cnt_inc_c;
  logic                         flag_q, flag_d;
`endif

  // Region decode of the incoming request
  assign req_region_c = bus.cpu_address_2x[DECODE_LSB +: 2];
  assign req_sel_c    = 4'b0001 << req_region_c;
  assign req_mapped_c = |(req_sel_c & REGION_MASK);

  // Only the selected region's ack counts; others are ignored
  assign ack_hit_c = |(periph_ack_i & sel_q);

  // State and output registers
  always_ff @(posedge clk_2x or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
      sel_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
      flag_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      re_q    <= re_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    rdata_d    = rdata_q;
    sel_d      = sel_q;
    re_d       = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    ack_data_c = '0;
`ifdef BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
    flag_d     = flag_q;
    cnt_inc_c  = cnt_q + CNT_W'(1);
`endif

    for (int unsigned i = 0; i < REGIONS; i++) begin
      if (sel_q[i]) ack_data_c = ack_data_c | periph_read_data_i[DATA_W*i +: DATA_W];
    end

    unique case (state_q)
      S_IDLE: begin
        // ready is always low here, so a new request waits at least one cycle after RESPOND
        if (bus.cpu_mem_valid_2x && !ready_q) begin
          addr_d  = bus.cpu_address_2x[PERIPH_ADDR_WIDTH-1:0];
          wdata_d = bus.cpu_write_data_2x;
          wstrb_d = bus.cpu_wstrb_2x;
          if (req_mapped_c) begin
            sel_d   = req_sel_c;
            re_d    = (bus.cpu_wstrb_2x == 4'b0000);
            we_d    = (bus.cpu_wstrb_2x != 4'b0000);
            state_d = S_STROBE;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            rdata_d = '0;
            ready_d = 1'b1;
            state_d = S_RESPOND;
          end
        end
      end

      S_STROBE, S_WAIT: begin
        if (!bus.cpu_mem_valid_2x) begin
          // Requester gave up: drop select silently, any later ack is ignored
          sel_d   = '0;
          state_d = S_IDLE;
        end else if (ack_hit_c) begin
          rdata_d = (wstrb_q == 4'b0000) ? ack_data_c : '0;
          ready_d = 1'b1;
          sel_d   = '0;
          state_d = S_RESPOND;
`ifdef BUS_TIMEOUT_EN
        end else if (cnt_inc_c == CNT_W'(TIMEOUT_CYCLES)) begin
          rdata_d = TIMEOUT_DATA;
          ready_d = 1'b1;
          sel_d   = '0;
          flag_d  = 1'b1;
          state_d = S_RESPOND;
`endif
        end else begin
`ifdef BUS_TIMEOUT_EN
          cnt_d   = cnt_inc_c;
`endif
          state_d = S_WAIT;
        end
      end

      S_RESPOND: begin
        if (!bus.cpu_mem_valid_2x) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cpu_mem_ready   = ready_q;
  assign bus.cpu_read_data   = rdata_q;
  assign periph_sel_o        = sel_q;
  assign periph_re_o         = re_q;
  assign periph_we_o         = we_q;
  assign periph_address_o    = addr_q;
  assign periph_write_data_o = wdata_q;
  assign periph_wstrb_o      = wstrb_q;

`ifdef BUS_TIMEOUT_EN
  assign timeout_flag_o = flag_q;
  assign unused_c       = ^bus.cpu_address_2x;
`else
  assign timeout_flag_o = 1'b0;
  assign unused_c       = ^{bus.cpu_address_2x, TIMEOUT_DATA, 32'(TIMEOUT_CYCLES)};
`endif
endmodule
